// File: rtl/bus_pkg.sv
// Shared bus widths, the bridge target address and FSM state encodings for
// the bus-A initiator / bus-B split-target demo.
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] TARGET_ADDR   = 8'h80;
    localparam logic [DATA_W-1:0] DEFAULT_RDATA = 8'h00;

    typedef enum logic [1:0] {
        INIT_IDLE,
        INIT_WR,
        INIT_RD,
        INIT_WAIT_DATA
    } init_state_e;

    typedef enum logic [2:0] {
        BR_IDLE,
        BR_FWD_REQ,
        BR_WAIT_B_ACK,
        BR_WAIT_B_DATA,
        BR_RETURN
    } bridge_state_e;

endpackage

// File: rtl/bus_bridge.sv
// Bus A -> bus B bridge: writes are acked upstream once bus B acks, reads are
// split upstream immediately and the data is returned later with a valid pulse.
module bus_bridge
    import bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_req,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic              up_wr,
    input  logic [DATA_W-1:0] up_wdata,
    output logic              up_ack,
    output logic              up_split_ack,
    output logic              up_data_valid,
    output logic [DATA_W-1:0] up_data,
    output logic              dn_req,
    output logic [ADDR_W-1:0] dn_addr,
    output logic              dn_wr,
    output logic [DATA_W-1:0] dn_wdata,
    input  logic              dn_ack,
    input  logic              dn_data_valid,
    input  logic [DATA_W-1:0] dn_data
);

    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              split_ack_q, split_ack_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wr_d          = wr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        ack_d         = 1'b0;
        split_ack_d   = 1'b0;
        dn_req        = 1'b0;
        up_data_valid = 1'b0;
        case (state_q)
            BR_IDLE: begin
                // Upstream still shows req in the cycle our write ack is out.
                if (up_req && !ack_q) begin
                    addr_d      = up_addr;
                    wr_d        = up_wr;
                    wdata_d     = up_wdata;
                    split_ack_d = !up_wr;
                    state_d     = BR_FWD_REQ;
                end
            end
            BR_FWD_REQ: begin
                dn_req  = 1'b1;
                state_d = BR_WAIT_B_ACK;
            end
            BR_WAIT_B_ACK: begin
                dn_req = 1'b1;
                if (dn_ack) begin
                    if (wr_q) begin
                        ack_d   = 1'b1;
                        state_d = BR_IDLE;
                    end else begin
                        state_d = BR_WAIT_B_DATA;
                    end
                end
            end
            BR_WAIT_B_DATA: begin
                if (dn_data_valid) begin
                    rdata_d = dn_data;
                    state_d = BR_RETURN;
                end
            end
            BR_RETURN: begin
                up_data_valid = 1'b1;
                state_d       = BR_IDLE;
            end
            default: state_d = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BR_IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            split_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            split_ack_q <= split_ack_d;
        end
    end

    assign up_ack       = ack_q;
    assign up_split_ack = split_ack_q;
    assign up_data      = rdata_q;
    assign dn_addr      = addr_q;
    assign dn_wr        = wr_q;
    assign dn_wdata     = wdata_q;

endmodule

// File: rtl/system_top_bus_bridge.sv
// FPGA demo top: button-started write+read from a bus-A initiator, through the
// bridge, to a split-capable target on bus B; last written byte drives the LEDs.
module system_top_bus_bridge
    import bus_pkg::*;
#(
    parameter logic [DATA_W-1:0] WRITE_DATA    = 8'hA5,
    parameter logic [ADDR_W-1:0] TARGET_ADDR   = bus_pkg::TARGET_ADDR,
    parameter int                SPLIT_LATENCY = 4
)(
    input  logic       clk,
    input  logic       btn_reset,
    input  logic       btn_trigger,
    output logic [7:0] leds
);

    localparam int CNT_W = $clog2(SPLIT_LATENCY + 1);

    logic rst_meta_q, rst_sync_q;
    logic rst_n;

    always_ff @(posedge clk) begin
        rst_meta_q <= btn_reset;
        rst_sync_q <= rst_meta_q;
    end

    assign rst_n = ~rst_sync_q;

    logic trig_meta_q, trig_sync_q, trig_prev_q;
    logic trig_edge;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            trig_meta_q <= btn_trigger;
            trig_sync_q <= trig_meta_q;
            trig_prev_q <= trig_sync_q;
        end
    end

    assign trig_edge = trig_sync_q & ~trig_prev_q;

    // Bus A nets
    logic              a_req, a_wr, a_sel;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack, a_split_ack;
    logic              init1_data_in_valid;
    logic [DATA_W-1:0] init1_data_in;

    // Bus B nets
    logic              bridge_init_req, bridge_init_wr;
    logic [ADDR_W-1:0] bridge_init_addr;
    logic [DATA_W-1:0] bridge_init_wdata;
    logic              bridge_init_ack, bridge_init_split_ack;
    logic              bridge_init_data_in_valid;
    logic [DATA_W-1:0] bridge_init_data_in;

    logic              br_up_ack, br_up_data_valid;
    logic [DATA_W-1:0] br_up_data;

    init_state_e init_state_q, init_state_d;

    always_comb begin
        init_state_d = init_state_q;
        a_req        = 1'b0;
        a_wr         = 1'b0;
        a_addr       = TARGET_ADDR;
        a_wdata      = WRITE_DATA;
        case (init_state_q)
            INIT_IDLE: begin
                if (trig_edge) init_state_d = INIT_WR;
            end
            INIT_WR: begin
                a_req = 1'b1;
                a_wr  = 1'b1;
                if (a_ack) init_state_d = INIT_RD;
            end
            INIT_RD: begin
                a_req = 1'b1;
                if (a_ack || a_split_ack) init_state_d = INIT_WAIT_DATA;
            end
            INIT_WAIT_DATA: begin
                if (init1_data_in_valid) init_state_d = INIT_IDLE;
            end
            default: init_state_d = INIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) init_state_q <= INIT_IDLE;
        else        init_state_q <= init_state_d;
    end

    assign a_sel = (a_addr == TARGET_ADDR);

    // Default responder for unmapped bus-A addresses: ack, then 8'h00 on reads.
    logic dflt_ack_q, dflt_ack_d, dflt_rd_q, dflt_rd_d, dflt_vld_q, dflt_vld_d;

    always_comb begin
        dflt_ack_d = a_req && !a_sel && !dflt_ack_q && !dflt_rd_q;
        dflt_rd_d  = dflt_ack_d && !a_wr;
        dflt_vld_d = dflt_rd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dflt_ack_q <= 1'b0;
            dflt_rd_q  <= 1'b0;
            dflt_vld_q <= 1'b0;
        end else begin
            dflt_ack_q <= dflt_ack_d;
            dflt_rd_q  <= dflt_rd_d;
            dflt_vld_q <= dflt_vld_d;
        end
    end

    assign a_ack               = br_up_ack | dflt_ack_q;
    assign a_split_ack         = bridge_init_split_ack;
    assign init1_data_in_valid = br_up_data_valid | dflt_vld_q;
    assign init1_data_in       = dflt_vld_q ? DEFAULT_RDATA : br_up_data;

    bus_bridge u_bridge (
        .clk           (clk),
        .rst_n         (rst_n),
        .up_req        (a_req && a_sel),
        .up_addr       (a_addr),
        .up_wr         (a_wr),
        .up_wdata      (a_wdata),
        .up_ack        (br_up_ack),
        .up_split_ack  (bridge_init_split_ack),
        .up_data_valid (br_up_data_valid),
        .up_data       (br_up_data),
        .dn_req        (bridge_init_req),
        .dn_addr       (bridge_init_addr),
        .dn_wr         (bridge_init_wr),
        .dn_wdata      (bridge_init_wdata),
        .dn_ack        (bridge_init_ack),
        .dn_data_valid (bridge_init_data_in_valid),
        .dn_data       (bridge_init_data_in)
    );

    // Split target on bus B; the ack/valid guards keep one transaction in flight.
    logic              tgt_ack_q, tgt_ack_d;
    logic              tgt_pend_q, tgt_pend_d;
    logic              tgt_vld_q, tgt_vld_d;
    logic [CNT_W-1:0]  tgt_cnt_q, tgt_cnt_d;
    logic [DATA_W-1:0] tgt_data_q, tgt_data_d;
    logic [DATA_W-1:0] b_split_target_last_write_q, b_split_target_last_write_d;
    logic [DATA_W-1:0] b_split_target_last_write;
    logic [7:0]        leds_q;

    always_comb begin
        tgt_ack_d                   = 1'b0;
        tgt_vld_d                   = 1'b0;
        tgt_pend_d                  = tgt_pend_q;
        tgt_cnt_d                   = tgt_cnt_q;
        tgt_data_d                  = tgt_data_q;
        b_split_target_last_write_d = b_split_target_last_write_q;
        if (bridge_init_req && (bridge_init_addr == TARGET_ADDR) &&
            !tgt_ack_q && !tgt_pend_q && !tgt_vld_q) begin
            tgt_ack_d = 1'b1;
            if (bridge_init_wr) begin
                b_split_target_last_write_d = bridge_init_wdata;
            end else begin
                tgt_pend_d = 1'b1;
                tgt_cnt_d  = CNT_W'(SPLIT_LATENCY);
            end
        end
        if (tgt_pend_q) begin
            tgt_cnt_d = tgt_cnt_q - CNT_W'(1);
            if (tgt_cnt_q == CNT_W'(1)) begin
                tgt_pend_d = 1'b0;
                tgt_vld_d  = 1'b1;
                tgt_data_d = b_split_target_last_write_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt_ack_q                   <= 1'b0;
            tgt_pend_q                  <= 1'b0;
            tgt_vld_q                   <= 1'b0;
            tgt_cnt_q                   <= '0;
            tgt_data_q                  <= '0;
            b_split_target_last_write_q <= '0;
            leds_q                      <= 8'h00;
        end else begin
            tgt_ack_q                   <= tgt_ack_d;
            tgt_pend_q                  <= tgt_pend_d;
            tgt_vld_q                   <= tgt_vld_d;
            tgt_cnt_q                   <= tgt_cnt_d;
            tgt_data_q                  <= tgt_data_d;
            b_split_target_last_write_q <= b_split_target_last_write_d;
            leds_q                      <= b_split_target_last_write_q;
        end
    end

    assign bridge_init_ack           = tgt_ack_q;
    assign bridge_init_data_in_valid = tgt_vld_q;
    assign bridge_init_data_in       = tgt_data_q;
    assign b_split_target_last_write = b_split_target_last_write_q;
    assign leds                      = leds_q;

endmodule

// File: tb/tb_system_top_bus_bridge.sv
// Directed bench for the bus bridge demo top: reset, single trigger,
// held trigger and reset in the middle of a split read.
module tb_system_top_bus_bridge;

    logic       clk = 1'b0;
    logic       btn_reset = 1'b1;
    logic       btn_trigger = 1'b0;
    logic [7:0] leds;

    int checks = 0;
    int errors = 0;

    system_top_bus_bridge dut (
        .clk         (clk),
        .btn_reset   (btn_reset),
        .btn_trigger (btn_trigger),
        .leds        (leds)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        btn_reset   = 1'b1;
        btn_trigger = 1'b0;
        cycles(6);
        checks++;
        if (dut.rst_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_rst_n_low: got %b want 0", dut.rst_n);
        end
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL reset_leds_in_reset: got %h want 00", leds);
        end
        btn_reset = 1'b0;
        cycles(6);
        checks++;
        if (dut.rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_rst_n_released: got %b want 1", dut.rst_n);
        end
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL reset_leds_after: got %h want 00", leds);
        end
        checks++;
        if (dut.init1_data_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_init1_valid: got %b want 0", dut.init1_data_in_valid);
        end
    endtask

    task automatic test_single_transaction();
        bit         seen_req = 0, seen_ack = 0, order_ok;
        int         split_cyc = -1, bvld_cyc = -1, lw_cyc = -1, ivld_cnt = 0;
        logic [7:0] bdata = 8'h00, idata = 8'h00, led_at_lw = 8'hxx, led_after = 8'hxx;
        btn_trigger = 1'b1;
        cycles(1);
        btn_trigger = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dut.bridge_init_req === 1'b1) seen_req = 1;
            if (dut.bridge_init_ack === 1'b1) seen_ack = 1;
            if (dut.bridge_init_split_ack === 1'b1 && split_cyc < 0) split_cyc = c;
            if (dut.bridge_init_data_in_valid === 1'b1 && bvld_cyc < 0) begin
                bvld_cyc = c;
                bdata    = dut.bridge_init_data_in;
            end
            if (dut.init1_data_in_valid === 1'b1) begin
                ivld_cnt++;
                idata = dut.init1_data_in;
            end
            if (lw_cyc >= 0 && c == lw_cyc + 1) led_after = leds;
            if (lw_cyc < 0 && dut.b_split_target_last_write === 8'hA5) begin
                lw_cyc    = c;
                led_at_lw = leds;
            end
        end
        checks++;
        if (seen_req !== 1'b1) begin
            errors++;
            $display("FAIL single_bridge_req_seen: got %b want 1", seen_req);
        end
        checks++;
        if (seen_ack !== 1'b1) begin
            errors++;
            $display("FAIL single_bridge_ack_seen: got %b want 1", seen_ack);
        end
        checks++;
        if (dut.b_split_target_last_write !== 8'hA5) begin
            errors++;
            $display("FAIL single_last_write: got %h want a5", dut.b_split_target_last_write);
        end
        checks++;
        if (leds !== 8'hA5) begin
            errors++;
            $display("FAIL single_leds: got %h want a5", leds);
        end
        checks++;
        if (led_at_lw !== 8'h00) begin
            errors++;
            $display("FAIL single_leds_lag_old: got %h want 00", led_at_lw);
        end
        checks++;
        if (led_after !== 8'hA5) begin
            errors++;
            $display("FAIL single_leds_lag_new: got %h want a5", led_after);
        end
        order_ok = (split_cyc >= 0) && (bvld_cyc > split_cyc);
        checks++;
        if (order_ok !== 1'b1) begin
            errors++;
            $display("FAIL single_split_before_data: split at %0d data at %0d, want split earlier",
                     split_cyc, bvld_cyc);
        end
        checks++;
        if (bdata !== 8'hA5) begin
            errors++;
            $display("FAIL single_bridge_data_in: got %h want a5", bdata);
        end
        checks++;
        if (ivld_cnt !== 1) begin
            errors++;
            $display("FAIL single_init1_valid_count: got %0d want 1", ivld_cnt);
        end
        checks++;
        if (idata !== 8'hA5) begin
            errors++;
            $display("FAIL single_init1_data_in: got %h want a5", idata);
        end
    endtask

    task automatic test_held_trigger();
        int wr_acks = 0, rd_acks = 0, ivld_cnt = 0;
        btn_trigger = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c == 20) btn_trigger = 1'b0;
            @(negedge clk);
            if (dut.bridge_init_ack === 1'b1 && dut.bridge_init_wr === 1'b1) wr_acks++;
            if (dut.bridge_init_ack === 1'b1 && dut.bridge_init_wr === 1'b0) rd_acks++;
            if (dut.init1_data_in_valid === 1'b1) ivld_cnt++;
        end
        checks++;
        if (wr_acks !== 1) begin
            errors++;
            $display("FAIL held_write_count: got %0d want 1", wr_acks);
        end
        checks++;
        if (rd_acks !== 1) begin
            errors++;
            $display("FAIL held_read_count: got %0d want 1", rd_acks);
        end
        checks++;
        if (ivld_cnt !== 1) begin
            errors++;
            $display("FAIL held_init1_valid_count: got %0d want 1", ivld_cnt);
        end
    endtask

    task automatic test_reset_mid_transaction();
        bit         found = 0;
        int         ivld_cnt = 0;
        logic [7:0] idata = 8'h00;
        btn_trigger = 1'b1;
        cycles(1);
        btn_trigger = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (dut.bridge_init_ack === 1'b1 && dut.bridge_init_wr === 1'b0) found = 1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_ack_timeout: got %b want 1", found);
        end
        btn_reset = 1'b1;
        cycles(6);
        checks++;
        if (dut.init1_data_in_valid !== 1'b0 || dut.bridge_init_data_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_valids_low: got init1=%b bridge=%b want 0 0",
                     dut.init1_data_in_valid, dut.bridge_init_data_in_valid);
        end
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL mid_leds_reset: got %h want 00", leds);
        end
        checks++;
        if (dut.b_split_target_last_write !== 8'h00) begin
            errors++;
            $display("FAIL mid_last_write_reset: got %h want 00", dut.b_split_target_last_write);
        end
        btn_reset = 1'b0;
        cycles(6);
        btn_trigger = 1'b1;
        cycles(1);
        btn_trigger = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dut.init1_data_in_valid === 1'b1) begin
                ivld_cnt++;
                idata = dut.init1_data_in;
            end
        end
        checks++;
        if (ivld_cnt !== 1) begin
            errors++;
            $display("FAIL mid_retry_valid_count: got %0d want 1", ivld_cnt);
        end
        checks++;
        if (idata !== 8'hA5) begin
            errors++;
            $display("FAIL mid_retry_data: got %h want a5", idata);
        end
        checks++;
        if (leds !== 8'hA5) begin
            errors++;
            $display("FAIL mid_retry_leds: got %h want a5", leds);
        end
    endtask

    initial begin
        test_reset();
        test_single_transaction();
        test_held_trigger();
        test_reset_mid_transaction();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/system_top_bus_bridge.md
# system_top_bus_bridge

Self-contained demo top: a button-triggered initiator on bus A performs a write then a read to an address mapped through a bus bridge onto bus B. On bus B a split-capable target stores the write and returns the read data after a fixed delay. The readback returns to the initiator, and the last written byte is shown on the LEDs. It sits at FPGA top level, driven directly by board clock and buttons.

## Interface
- `WRITE_DATA`, 8'hA5: byte written by initiator 1 on each trigger.
- `TARGET_ADDR`, 8'h80: bus-A address decoded to the bridge; forwarded unchanged to bus B.
- `SPLIT_LATENCY`, 4: cycles from split-target read acknowledge to read-data valid; ≥1.
- `clk`  in  1  single system clock; everything is synchronous to it.
- `btn_reset`  in  1  reset, synchronous and active-high. Passed through a 2-flop synchronizer; internal `rst_n` = inverted synchronized value.
- `btn_trigger`  in  1  start request; 2-flop synchronized, rising-edge detected.
- `leds`  out  8  mirror of `b_split_target_last_write`; 8'h00 in reset.

## Operation
- Required internal net names (the bench probes them hierarchically): `rst_n`, `init1_data_in`, `init1_data_in_valid`, `bridge_init_req`, `bridge_init_ack`, `bridge_init_split_ack`, `bridge_init_data_in`, `bridge_init_data_in_valid`, `b_split_target_last_write`.
- Bus protocol (A and B identical), initiator side:
  - Initiator drives `req`, `addr[7:0]`, `wr`, `wdata[7:0]`.
  - Target answers with a 1-cycle `ack`, or a 1-cycle `split_ack` on reads.
  - Read data returns with a 1-cycle `data_valid` plus `data[7:0]`.
  - `req` is held until `ack` or `split_ack`, then dropped.
- Initiator 1 FSM:
  - IDLE → on trigger edge → WR: req, wr=1, addr=`TARGET_ADDR`, data=`WRITE_DATA`.
  - WR → on ack → RD: req, wr=0, same addr.
  - RD → on split_ack → WAIT_DATA → on `init1_data_in_valid` → IDLE, data captured.
  - Trigger edges outside IDLE are ignored.
- Bridge FSM: IDLE, FWD_REQ, WAIT_B_ACK, WAIT_B_DATA, RETURN.
  - Upstream write: forward on bus B (`bridge_init_req`), then ack upstream once `bridge_init_ack` arrives.
  - Upstream read: pulse `bridge_init_split_ack` upstream in the cycle after req is seen, then issue the read on bus B.
  - On `bridge_init_data_in_valid`: latch `bridge_init_data_in`, then pulse `init1_data_in_valid` with `init1_data_in` = latched data.
- Split target (bus B):
  - Write: ack 1 cycle after req; `b_split_target_last_write` <= wdata.
  - Read: ack 1 cycle after req; data_valid `SPLIT_LATENCY` cycles after the ack, data = `b_split_target_last_write`.
  - A new req is not accepted while a read is pending.
- Addresses other than `TARGET_ADDR` on bus A: a default responder acks and returns 8'h00. Never occurs in the normal flow.

## Timing
- Reset: all FSMs IDLE, all req/ack/valid low, data regs and `leds` 8'h00. `rst_n` deasserts 2–3 cycles after `btn_reset` falls.
- Trigger: first bus-A req 3 cycles after the `btn_trigger` rising edge (2 sync + 1 edge).
- Write path ≈ 6 cycles; read path ≈ 6 + `SPLIT_LATENCY` cycles. Exact counts are not checked.
- `leds` updates 1 cycle after `b_split_target_last_write`.
- Reset mid-transaction aborts every FSM to IDLE; in-flight data is discarded.
- Trigger held high for many cycles starts exactly one transaction.

## Structure
- Package `bus_pkg`: bus address width/constants, `TARGET_ADDR`, FSM state enums.
- Sub-module `bus_bridge` (upstream target port and downstream initiator port). Initiator 1, split target and the synchronizers stay inline in the top.

## Test plan
- Hold `btn_reset` for 6 cycles, release, wait 6 cycles → `rst_n`=1, `leds`=8'h00, `init1_data_in_valid` low.
- One-cycle trigger pulse → `bridge_init_req` seen, `bridge_init_ack` seen, `b_split_target_last_write`=8'hA5, `leds`=8'hA5.
- Same run → `bridge_init_split_ack` pulses before `bridge_init_data_in_valid`; `bridge_init_data_in`=8'hA5.
- Same run → `init1_data_in_valid` pulses once, `init1_data_in`=8'hA5, within well under 200 ms.
- Trigger held 20 cycles → exactly one write and one read on bus B.
- Reset asserted during WAIT_B_DATA → all valids low, `leds`=8'h00. A subsequent trigger completes with 8'hA5.
